// File: rtl/led_seq_pkg.sv
// Shared types for the LED ping-pong sequencer and its checker.
// Direction encoding is common to both sides of the loopback.
package led_seq_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } chk_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/led_sequence_checker_onehot.sv
// One-hot LED bus decoder: index of the lit LED and an
// exactly-one-bit-set flag.
module onehot_to_index
  import led_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 is_onehot
);

  localparam int W = $clog2(N);

  logic [N-1:0] low_clr;

  assign low_clr = vec & (vec - N'(1));
  assign is_onehot = (vec != '0) && (low_clr == '0);

  // OR of set-bit indices; only meaningful when is_onehot
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = idx | W'(i);
      end
    end
  end

endmodule

// File: rtl/led_sequence_checker.sv
// Receive-side checker for the LED ping-pong bounce pattern:
// tracks lock, position and direction, and counts violations.
module led_sequence_checker
  import led_seq_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_LEDS-1:0]         led_in,
  input  logic                      led_vld,
  output logic                      locked,
  output logic [$clog2(N_LEDS)-1:0] pos,
  output logic                      dir_up,
  output logic                      err,
  output logic [CNT_W-1:0]          err_cnt
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW:0]   ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

  chk_state_t state, state_nx;

  logic [PW-1:0]    pos_nx;
  logic             dir_nx;
  logic             err_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] cnt_inc;

  logic [PW-1:0] idx;
  logic          good;
  logic [PW:0]   pos_w;
  logic [PW:0]   idx_w;
  logic [PW:0]   exp_w;
  logic          adj;
  logic          hit;
  logic          bdir;

  onehot_to_index #(
    .N(N_LEDS)
  ) u_dec (
    .vec      (led_in),
    .idx      (idx),
    .is_onehot(good)
  );

  assign pos_w = {1'b0, pos};
  assign idx_w = {1'b0, idx};

  // Extra MSB keeps pos-1 at pos=0 from aliasing a real index
  assign exp_w = dir_up ? pos_w + ONE : pos_w - ONE;
  assign hit   = good && (idx_w == exp_w);
  assign adj   = (idx_w == pos_w + ONE) ||
                 (pos_w == idx_w + ONE);

  assign cnt_inc = (&err_cnt) ? err_cnt
                              : err_cnt + CNT_W'(1);

  always_comb begin
    bdir = dir_up;
    unique case (1'b1)
      (idx == LAST): bdir = DIR_DOWN;
      (idx == '0):   bdir = DIR_UP;
      default:       bdir = (idx > pos);
    endcase
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    dir_nx   = dir_up;
    err_nx   = 1'b0;
    cnt_nx   = err_cnt;
    if (led_vld) begin
      unique case (state)
        HUNT: begin
          if (good) begin
            pos_nx   = idx;
            state_nx = SYNC;
          end
        end
        SYNC: begin
          if (!good) begin
            state_nx = HUNT;
          end else begin
            pos_nx = idx;
            if (adj) begin
              dir_nx   = bdir;
              state_nx = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (hit) begin
            pos_nx = idx;
            dir_nx = bdir;
          end else begin
            err_nx = 1'b1;
            cnt_nx = cnt_inc;
            if (good) begin
              pos_nx   = idx;
              state_nx = SYNC;
            end else begin
              state_nx = HUNT;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      pos     <= '0;
      dir_up  <= DIR_UP;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nx;
      pos     <= pos_nx;
      dir_up  <= dir_nx;
      err     <= err_nx;
      err_cnt <= cnt_nx;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_led_sequence_checker.sv
// Scoreboard bench: three checker instances (N=4/CNT_W=8,
// N=4/CNT_W=2, N=2) driven with hand-computed vectors.
module tb_led_sequence_checker;

  typedef struct packed {
    logic       lk;
    logic [3:0] pos;
    logic       dir;
    logic       err;
    logic [7:0] cnt;
  } obs_t;

  localparam obs_t RST = '{lk: 1'b0, pos: 4'd0, dir: 1'b1,
                           err: 1'b0, cnt: 8'd0};

  logic       clk = 1'b0;
  logic [2:0] rstn = 3'b000;
  logic [2:0] vld = 3'b000;
  logic [2:0] vld_d = 3'b000;
  logic [3:0] led_a = '0;
  logic [3:0] led_b = '0;
  logic [1:0] led_c = '0;

  logic       lk_a, dir_a, err_a;
  logic [1:0] pos_a;
  logic [7:0] cnt_a;
  logic       lk_b, dir_b, err_b;
  logic [1:0] pos_b;
  logic [1:0] cnt_b;
  logic       lk_c, dir_c, err_c;
  logic [0:0] pos_c;
  logic [7:0] cnt_c;

  obs_t got[3];
  obs_t last[3];
  obs_t q[3][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sequence_checker #(.N_LEDS(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rstn[0]), .led_in(led_a),
    .led_vld(vld[0]), .locked(lk_a), .pos(pos_a),
    .dir_up(dir_a), .err(err_a), .err_cnt(cnt_a));

  led_sequence_checker #(.N_LEDS(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rstn[1]), .led_in(led_b),
    .led_vld(vld[1]), .locked(lk_b), .pos(pos_b),
    .dir_up(dir_b), .err(err_b), .err_cnt(cnt_b));

  led_sequence_checker #(.N_LEDS(2), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rstn[2]), .led_in(led_c),
    .led_vld(vld[2]), .locked(lk_c), .pos(pos_c),
    .dir_up(dir_c), .err(err_c), .err_cnt(cnt_c));

  assign got[0] = {lk_a, 2'b00, pos_a, dir_a, err_a, cnt_a};
  assign got[1] = {lk_b, 2'b00, pos_b, dir_b, err_b,
                   6'b0, cnt_b};
  assign got[2] = {lk_c, 3'b000, pos_c, dir_c, err_c, cnt_c};

  function automatic obs_t mk(input logic lk, input int p,
                              input logic dr, input logic er,
                              input int c);
    obs_t o;
    o.lk  = lk;
    o.pos = 4'(p);
    o.dir = dr;
    o.err = er;
    o.cnt = 8'(c);
    return o;
  endfunction

  task automatic chk(input int d, input string nm,
                     input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL dut%0d %s t=%0t got lk=%b pos=%0d dir=%b err=%b cnt=%0d want lk=%b pos=%0d dir=%b err=%b cnt=%0d",
               d, nm, $time, g.lk, g.pos, g.dir, g.err, g.cnt,
               e.lk, e.pos, e.dir, e.err, e.cnt);
    end
  endtask

  always @(posedge clk) vld_d <= vld & rstn;

  // Monitor: a sample accepted last edge must match the queue head;
  // otherwise outputs must hold and err must be low
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rstn[d]) begin
        chk(d, "reset", got[d], RST);
        last[d] = RST;
      end else if (vld_d[d]) begin
        if (q[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d underflow got sample want none", d);
        end else begin
          obs_t e;
          e = q[d].pop_front();
          chk(d, "step", got[d], e);
          last[d] = e;
          last[d].err = 1'b0;
        end
      end else begin
        chk(d, "hold", got[d], last[d]);
      end
    end
  end

  task automatic step(input int d, input logic [3:0] v,
                      input obs_t e);
    @(negedge clk);
    case (d)
      0: led_a = v;
      1: led_b = v;
      default: led_c = v[1:0];
    endcase
    vld[d] = 1'b1;
    q[d].push_back(e);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld[d] = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) last[d] = RST;
    repeat (3) @(negedge clk);
    rstn = 3'b111;
    idle(0, 2);

    // Full bounce on N=4
    step(0, 4'b0001, mk(0, 0, 1, 0, 0));
    step(0, 4'b0010, mk(1, 1, 1, 0, 0));
    step(0, 4'b0100, mk(1, 2, 1, 0, 0));
    step(0, 4'b1000, mk(1, 3, 0, 0, 0));
    step(0, 4'b0100, mk(1, 2, 0, 0, 0));
    step(0, 4'b0010, mk(1, 1, 0, 0, 0));
    step(0, 4'b0001, mk(1, 0, 1, 0, 0));
    step(0, 4'b0010, mk(1, 1, 1, 0, 0));

    // Wrong-direction step, then relock
    step(0, 4'b0100, mk(1, 2, 1, 0, 0));
    step(0, 4'b0010, mk(0, 1, 1, 1, 1));
    step(0, 4'b0100, mk(1, 2, 1, 0, 1));

    // Blank bus while locked, then multi-hot in HUNT
    step(0, 4'b0000, mk(0, 2, 1, 1, 2));
    step(0, 4'b0110, mk(0, 2, 1, 0, 2));

    // Relock at top end, idle with garbage on the bus
    step(0, 4'b0100, mk(0, 2, 1, 0, 2));
    step(0, 4'b1000, mk(1, 3, 0, 0, 2));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vld[0] = 1'b0;
      led_a = 4'($urandom);
    end
    step(0, 4'b0100, mk(1, 2, 0, 0, 2));
    step(0, 4'b0100, mk(0, 2, 0, 1, 3));

    // Async reset between edges while a sample is in flight
    step(0, 4'b1000, mk(1, 3, 0, 0, 3));
    step(0, 4'b0100, mk(1, 2, 0, 0, 3));
    @(posedge clk);
    #2;
    rstn[0] = 1'b0;
    q[0].delete();
    #1;
    chk(0, "async_rst", got[0], RST);
    idle(0, 3);
    rstn[0] = 1'b1;
    idle(0, 1);
    step(0, 4'b0001, mk(0, 0, 1, 0, 0));
    step(0, 4'b0010, mk(1, 1, 1, 0, 0));
    idle(0, 2);

    // Saturating 2-bit counter
    step(1, 4'b0001, mk(0, 0, 1, 0, 0));
    step(1, 4'b0010, mk(1, 1, 1, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      step(1, 4'b0001, mk(0, 0, 1, 1, (k > 3) ? 3 : k));
      step(1, 4'b0010, mk(1, 1, 1, 0, (k > 3) ? 3 : k));
    end
    idle(1, 2);

    // Two-LED bus
    step(2, 4'b0001, mk(0, 0, 1, 0, 0));
    step(2, 4'b0010, mk(1, 1, 0, 0, 0));
    step(2, 4'b0001, mk(1, 0, 1, 0, 0));
    step(2, 4'b0010, mk(1, 1, 0, 0, 0));
    idle(2, 3);

    for (int d = 0; d < 3; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL dut%0d drain got %0d pending want 0",
                 d, q[d].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
